// File: rtl/biu_arb.sv
// rtl/biu_arb.sv - multi-port BIU arbiter with in-order response routing; BIU_ARB_ROUND_ROBIN_EN selects round-robin grant
package biu_arb_pkg;
    typedef logic [2:0] biu_size_t;
    typedef logic [2:0] biu_prot_t;
    typedef logic [2:0] biu_type_t;

    localparam biu_type_t SINGLE = 3'd0;
    localparam biu_type_t INCR   = 3'd1;
    localparam biu_type_t WRAP4  = 3'd2;
    localparam biu_type_t INCR4  = 3'd3;
    localparam biu_type_t WRAP8  = 3'd4;
    localparam biu_type_t INCR8  = 3'd5;
    localparam biu_type_t WRAP16 = 3'd6;
    localparam biu_type_t INCR16 = 3'd7;
endpackage

module biu_arb
    import biu_arb_pkg::*;
#(
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 32,
    parameter int PORTS       = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic      [PORTS-1:0]               biu_req_i,
    input  logic      [PORTS-1:0]               biu_lock_i,
    input  logic      [PORTS-1:0]               biu_we_i,
    input  logic      [PORTS-1:0][ADDR_SIZE-1:0] biu_adri_i,
    input  logic      [PORTS-1:0][DATA_SIZE-1:0] biu_d_i,
    input  biu_size_t [PORTS-1:0]               biu_size_i,
    input  biu_type_t [PORTS-1:0]               biu_type_i,
    input  biu_prot_t [PORTS-1:0]               biu_prot_i,
    output logic      [PORTS-1:0]               biu_req_ack_o,
    output logic      [PORTS-1:0]               biu_d_ack_o,
    output logic      [PORTS-1:0]               biu_ack_o,
    output logic      [PORTS-1:0]               biu_err_o,
    output logic      [PORTS-1:0][ADDR_SIZE-1:0] biu_adro_o,
    output logic      [PORTS-1:0][DATA_SIZE-1:0] biu_q_o,
    output logic                                biu_req_o,
    output logic      [ADDR_SIZE-1:0]           biu_adri_o,
    output biu_size_t                           biu_size_o,
    output biu_type_t                           biu_type_o,
    output logic                                biu_lock_o,
    output biu_prot_t                           biu_prot_o,
    output logic                                biu_we_o,
    output logic      [DATA_SIZE-1:0]           biu_d_o,
    input  logic                                biu_req_ack_i,
    input  logic                                biu_d_ack_i,
    input  logic      [ADDR_SIZE-1:0]           biu_adro_i,
    input  logic      [DATA_SIZE-1:0]           biu_q_i,
    input  logic                                biu_ack_i,
    input  logic                                biu_err_i
);
    localparam int IDX_W = $clog2(PORTS);
    localparam int QW    = $clog2(QUEUE_DEPTH);
    localparam int CW    = QW + 1;

    typedef logic [IDX_W-1:0] idx_t;

    logic [PORTS-1:0] eligible;
    logic [PORTS-1:0] head_sel;
    idx_t             gnt_idx;
    idx_t             head_port;
    logic             any_req;
    logic             accept;
    logic             head_valid;
    logic             pop;
    logic [3:0]       head_beats;
    logic [3:0]       cur_cnt;

    logic             lock_valid_q, lock_valid_d;
    idx_t             lock_port_q, lock_port_d;
    logic [QW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [QW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             q_full_q, q_full_d;
    logic             q_empty_q, q_empty_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cnt_loaded_q, cnt_loaded_d;
    idx_t             q_port_q  [QUEUE_DEPTH];
    idx_t             q_port_d  [QUEUE_DEPTH];
    logic [3:0]       q_beats_q [QUEUE_DEPTH];
    logic [3:0]       q_beats_d [QUEUE_DEPTH];
`ifdef BIU_ARB_ROUND_ROBIN_EN
    idx_t             ptr_q, ptr_d;
`endif

    function automatic logic [3:0] beats_m1(input biu_type_t t);
        case (t)
            WRAP4, INCR4:   beats_m1 = 4'd3;
            WRAP8, INCR8:   beats_m1 = 4'd7;
            WRAP16, INCR16: beats_m1 = 4'd15;
            default:        beats_m1 = 4'd0;
        endcase
    endfunction

    // A held lock narrows the candidate set to the locking port alone.
    always_comb begin
        eligible = biu_req_i;
        if (lock_valid_q) begin
            eligible = biu_req_i & (PORTS'(1) << lock_port_q);
        end
        any_req = |eligible;
    end

    // Scan from lowest priority to highest so the last hit wins.
    always_comb begin : grant_sel
`ifdef BIU_ARB_ROUND_ROBIN_EN
        int j;
        j       = 0;
        gnt_idx = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % PORTS;
            if (eligible[j]) begin
                gnt_idx = idx_t'(j);
            end
        end
`else
        gnt_idx = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                gnt_idx = idx_t'(k);
            end
        end
`endif
    end

    always_comb begin
        biu_req_o     = any_req & ~q_full_q & ~rst_i;
        accept        = biu_req_o & biu_req_ack_i;
        biu_req_ack_o = accept ? (PORTS'(1) << gnt_idx) : '0;
        biu_adri_o    = biu_adri_i[gnt_idx];
        biu_size_o    = biu_size_i[gnt_idx];
        biu_type_o    = biu_type_i[gnt_idx];
        biu_lock_o    = biu_lock_i[gnt_idx];
        biu_prot_o    = biu_prot_i[gnt_idx];
        biu_we_o      = biu_we_i[gnt_idx];
        biu_d_o       = biu_d_i[gnt_idx];
    end

    // Response side: only the head entry's port sees acknowledgements.
    always_comb begin
        head_port  = q_port_q[rd_ptr_q];
        head_beats = q_beats_q[rd_ptr_q];
        head_valid = ~q_empty_q & ~rst_i;
        cur_cnt    = cnt_loaded_q ? cnt_q : head_beats;
        pop        = head_valid & (biu_err_i | (biu_ack_i & (cur_cnt == 4'd0)));
        head_sel   = head_valid ? (PORTS'(1) << head_port) : '0;
        biu_ack_o   = head_sel & {PORTS{biu_ack_i}};
        biu_err_o   = head_sel & {PORTS{biu_err_i}};
        biu_d_ack_o = head_sel & {PORTS{biu_d_ack_i}};
        for (int p = 0; p < PORTS; p++) begin
            biu_q_o[p]    = biu_q_i;
            biu_adro_o[p] = biu_adro_i;
        end
    end

    always_comb begin
        q_port_d  = q_port_q;
        q_beats_d = q_beats_q;
        if (accept) begin
            q_port_d[wr_ptr_q]  = gnt_idx;
            q_beats_d[wr_ptr_q] = beats_m1(biu_type_i[gnt_idx]);
        end
        wr_ptr_d  = wr_ptr_q + QW'(accept);
        rd_ptr_d  = rd_ptr_q + QW'(pop);
        count_d   = count_q + CW'(accept) - CW'(pop);
        q_full_d  = (count_d == CW'(QUEUE_DEPTH));
        q_empty_d = (count_d == '0);
    end

    // The counter is only meaningful once the head has seen a beat; until then the head's own length is used.
    always_comb begin
        cnt_d        = cnt_q;
        cnt_loaded_d = cnt_loaded_q;
        if (pop) begin
            cnt_d        = 4'd0;
            cnt_loaded_d = 1'b0;
        end else if (head_valid && biu_ack_i) begin
            cnt_d        = cur_cnt - 4'd1;
            cnt_loaded_d = 1'b1;
        end
    end

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_port_d  = lock_port_q;
        if (lock_valid_q && !biu_req_i[lock_port_q]) begin
            lock_valid_d = 1'b0;
        end
        if (accept) begin
            lock_valid_d = biu_lock_i[gnt_idx];
            lock_port_d  = gnt_idx;
        end
    end

`ifdef BIU_ARB_ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = idx_t'((int'(gnt_idx) + 1) % PORTS);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            q_full_q     <= 1'b0;
            q_empty_q    <= 1'b1;
            cnt_q        <= 4'd0;
            cnt_loaded_q <= 1'b0;
            lock_valid_q <= 1'b0;
            lock_port_q  <= '0;
`ifdef BIU_ARB_ROUND_ROBIN_EN
            ptr_q        <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            q_full_q     <= q_full_d;
            q_empty_q    <= q_empty_d;
            cnt_q        <= cnt_d;
            cnt_loaded_q <= cnt_loaded_d;
            lock_valid_q <= lock_valid_d;
            lock_port_q  <= lock_port_d;
`ifdef BIU_ARB_ROUND_ROBIN_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        q_port_q  <= q_port_d;
        q_beats_q <= q_beats_d;
    end
endmodule

// File: tb/tb_biu_arb.sv
// tb/tb_biu_arb.sv - directed bench for biu_arb (depth-4 and depth-2 instances share stimulus)
module tb_biu_arb;
    import biu_arb_pkg::*;

    localparam int P = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic      [P-1:0]       req_i, lock_i, we_i;
    logic      [P-1:0][31:0] adri_i, d_i;
    biu_size_t [P-1:0]       size_i;
    biu_type_t [P-1:0]       type_i;
    biu_prot_t [P-1:0]       prot_i;
    logic                    s_req_ack, s_d_ack, s_ack, s_err;
    logic      [31:0]        s_adro, s_q;

    logic      [P-1:0]       req_ack_o, d_ack_o, ack_o, err_o;
    logic      [P-1:0][31:0] adro_o, q_o;
    logic                    m_req, m_lock, m_we;
    logic      [31:0]        m_adri, m_d;
    biu_size_t               m_size;
    biu_type_t               m_type;
    biu_prot_t               m_prot;

    logic      [P-1:0]       b_req_ack_o, b_d_ack_o, b_ack_o, b_err_o;
    logic      [P-1:0][31:0] b_adro_o, b_q_o;
    logic                    b_req, b_lock, b_we;
    logic      [31:0]        b_adri, b_d;
    biu_size_t               b_size;
    biu_type_t               b_type;
    biu_prot_t               b_prot;

    int n_cmp;
    int n_bad;
    logic [3:0] exp_g [5];

    biu_arb #(.ADDR_SIZE(32), .DATA_SIZE(32), .PORTS(P), .QUEUE_DEPTH(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .biu_req_i(req_i), .biu_lock_i(lock_i), .biu_we_i(we_i),
        .biu_adri_i(adri_i), .biu_d_i(d_i),
        .biu_size_i(size_i), .biu_type_i(type_i), .biu_prot_i(prot_i),
        .biu_req_ack_o(req_ack_o), .biu_d_ack_o(d_ack_o), .biu_ack_o(ack_o), .biu_err_o(err_o),
        .biu_adro_o(adro_o), .biu_q_o(q_o),
        .biu_req_o(m_req), .biu_adri_o(m_adri), .biu_size_o(m_size), .biu_type_o(m_type),
        .biu_lock_o(m_lock), .biu_prot_o(m_prot), .biu_we_o(m_we), .biu_d_o(m_d),
        .biu_req_ack_i(s_req_ack), .biu_d_ack_i(s_d_ack), .biu_adro_i(s_adro), .biu_q_i(s_q),
        .biu_ack_i(s_ack), .biu_err_i(s_err)
    );

    biu_arb #(.ADDR_SIZE(32), .DATA_SIZE(32), .PORTS(P), .QUEUE_DEPTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .biu_req_i(req_i), .biu_lock_i(lock_i), .biu_we_i(we_i),
        .biu_adri_i(adri_i), .biu_d_i(d_i),
        .biu_size_i(size_i), .biu_type_i(type_i), .biu_prot_i(prot_i),
        .biu_req_ack_o(b_req_ack_o), .biu_d_ack_o(b_d_ack_o), .biu_ack_o(b_ack_o), .biu_err_o(b_err_o),
        .biu_adro_o(b_adro_o), .biu_q_o(b_q_o),
        .biu_req_o(b_req), .biu_adri_o(b_adri), .biu_size_o(b_size), .biu_type_o(b_type),
        .biu_lock_o(b_lock), .biu_prot_o(b_prot), .biu_we_o(b_we), .biu_d_o(b_d),
        .biu_req_ack_i(s_req_ack), .biu_d_ack_i(s_d_ack), .biu_adro_i(s_adro), .biu_q_i(s_q),
        .biu_ack_i(s_ack), .biu_err_i(s_err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        req_i = '0; lock_i = '0; we_i = '0;
        for (int i = 0; i < P; i++) begin
            adri_i[i] = 32'h1000 * (i + 1);
            d_i[i]    = 32'hD0 + i;
            size_i[i] = 3'd2;
            type_i[i] = SINGLE;
            prot_i[i] = 3'd0;
        end
        s_req_ack = 1'b0; s_d_ack = 1'b0; s_ack = 1'b0; s_err = 1'b0;
        s_adro = 32'h0; s_q = 32'h0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_in();
        rst = 1'b1;

        // Everything active during reset must stay invisible.
        req_i = 4'hF; s_req_ack = 1'b1; s_ack = 1'b1; s_err = 1'b1; s_d_ack = 1'b1;
        settle();
        chk("rst_req_o", m_req, 0);
        chk("rst_req_ack_o", req_ack_o, 0);
        chk("rst_ack_o", ack_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_d_ack_o", d_ack_o, 0);
        chk("rst_req_o_qd2", b_req, 0);
        tick();
        tick();
        rst = 1'b0;
        clear_in();
        s_ack = 1'b1;
        settle();
        chk("empty_ack_drop", ack_o, 0);
        chk("idle_req_o", m_req, 0);
        tick();

        // All four ports requesting continuously
        do_reset();
`ifdef BIU_ARB_ROUND_ROBIN_EN
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        req_i = 4'hF; s_req_ack = 1'b1; s_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("all_grant%0d", k), req_ack_o, exp_g[k]);
            chk($sformatf("all_route%0d", k), ack_o, (k == 0) ? 4'b0000 : exp_g[k-1]);
            tick();
        end
        req_i = '0; s_req_ack = 1'b0;
        settle();
        chk("all_drain", ack_o, exp_g[4]);
        tick();

        // Ports 0 and 2 together, fixed order then ordered responses
        do_reset();
        req_i = 4'b0101; s_req_ack = 1'b1;
        settle();
        chk("p02_req_o", m_req, 1);
        chk("p02_gnt0", req_ack_o, 4'b0001);
        chk("p02_adri0", m_adri, 32'h1000);
        tick();
        req_i = 4'b0100;
        settle();
        chk("p02_gnt2", req_ack_o, 4'b0100);
        chk("p02_adri2", m_adri, 32'h3000);
        tick();
        req_i = '0; s_req_ack = 1'b0; s_ack = 1'b1; s_q = 32'hAAAA5555;
        settle();
        chk("p02_ack0", ack_o, 4'b0001);
        chk("q_broadcast", q_o, {4{32'hAAAA5555}});
        chk("idle_adri_port0", m_adri, 32'h1000);
        tick();
        settle();
        chk("p02_ack2", ack_o, 4'b0100);
        tick();

        // Depth-2 instance: full blocks request even with a simultaneous pop
        do_reset();
        req_i = 4'b0001; s_req_ack = 1'b1;
        settle();
        chk("qd2_req1", b_req, 1);
        tick();
        settle();
        chk("qd2_req2", b_req, 1);
        tick();
        settle();
        chk("qd2_full", b_req, 0);
        tick();
        s_ack = 1'b1;
        settle();
        chk("qd2_full_pop", b_req, 0);
        chk("qd2_ack0", b_ack_o, 4'b0001);
        tick();
        s_ack = 1'b0;
        settle();
        chk("qd2_reopen", b_req, 1);
        tick();

        // INCR4 on port 1 then SINGLE on port 0
        do_reset();
        req_i = 4'b0010; type_i[1] = INCR4; s_req_ack = 1'b1;
        settle();
        chk("burst_gnt1", req_ack_o, 4'b0010);
        chk("burst_type_o", m_type, INCR4);
        tick();
        req_i = 4'b0001; type_i[1] = SINGLE;
        settle();
        chk("burst_gnt0", req_ack_o, 4'b0001);
        tick();
        req_i = '0; s_req_ack = 1'b0; s_ack = 1'b1; s_d_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("burst_ack%0d", k), ack_o, (k < 4) ? 4'b0010 : 4'b0001);
            chk($sformatf("burst_dack%0d", k), d_ack_o, (k < 4) ? 4'b0010 : 4'b0001);
            tick();
        end
        settle();
        chk("burst_after_empty", ack_o, 0);
        tick();

        // Same bursts, error on beat 2 terminates port 1
        do_reset();
        req_i = 4'b0010; type_i[1] = INCR4; s_req_ack = 1'b1;
        tick();
        req_i = 4'b0001; type_i[1] = SINGLE;
        tick();
        req_i = '0; s_req_ack = 1'b0; s_ack = 1'b1;
        settle();
        chk("err_beat1", ack_o, 4'b0010);
        tick();
        s_ack = 1'b0; s_err = 1'b1;
        settle();
        chk("err_route", err_o, 4'b0010);
        chk("err_no_ack", ack_o, 0);
        tick();
        s_err = 1'b0; s_ack = 1'b1;
        settle();
        chk("err_next_p0", ack_o, 4'b0001);
        tick();

        // Lock held by port 3 against port 0
        do_reset();
        s_req_ack = 1'b1;
        req_i = 4'b1000; lock_i = 4'b1000;
        settle();
        chk("lock_gnt3a", req_ack_o, 4'b1000);
        chk("lock_o_set", m_lock, 1);
        tick();
        req_i = 4'b1001;
        settle();
        chk("lock_gnt3b", req_ack_o, 4'b1000);
        tick();
        lock_i = 4'b0000;
        settle();
        chk("lock_gnt3c", req_ack_o, 4'b1000);
        chk("lock_o_clr", m_lock, 0);
        tick();
        req_i = 4'b0001;
        settle();
        chk("lock_gnt0", req_ack_o, 4'b0001);
        tick();

        // Reset with three entries outstanding
        do_reset();
        req_i = 4'b0001; s_req_ack = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1; s_ack = 1'b1;
        settle();
        chk("midrst_req_o", m_req, 0);
        chk("midrst_req_ack", req_ack_o, 0);
        chk("midrst_ack", ack_o, 0);
        tick();
        rst = 1'b0; req_i = '0; s_req_ack = 1'b0; s_ack = 1'b1; s_err = 1'b1;
        settle();
        chk("postrst_ack", ack_o, 0);
        chk("postrst_err", err_o, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
